uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, sets the busy-wait limit in clk cycles; it is used only when UART_ARB_TIMEOUT_EN is defined.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 req  input  4  per-requester transmit request, bit i = requester i.
REQ-005 req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-006 gnt  output  4  one-hot, one-cycle pulse: the byte of requester i has been latched.
REQ-007 done  output  4  one-hot, one-cycle pulse: the frame of requester i has completed.
REQ-008 err  output  1  one-cycle pulse: the transmitter did not respond (timeout).
REQ-009 Tx_DATA  output  8  byte to the shared uart_transmitter.
REQ-010 Tx_WR  output  1  one-cycle write strobe to the transmitter.
REQ-011 Tx_EN  output  1  transmitter enable; high in every state except IDLE.
REQ-012 Tx_BUSY  input  1  transmitter busy flag.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have the states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-015 IDLE: if req != 0, select a winner by round-robin starting at (last+1) mod 4, latch its byte and index, pulse gnt[winner] and go to LOAD next cycle.
REQ-016 IDLE with req == 0 SHALL hold all outputs low.
REQ-017 LOAD: drive Tx_DATA with the latched byte, pulse Tx_WR for exactly one cycle, then go to WAIT_BUSY.
REQ-018 WAIT_BUSY: Tx_BUSY=1 -> go to WAIT_DONE; otherwise hold.
REQ-019 WAIT_DONE: Tx_BUSY=0 -> pulse done[owner], set last=owner and return to IDLE; otherwise hold.
REQ-020 Tx_DATA SHALL stay stable from LOAD until the exit from WAIT_DONE.
REQ-021 req and req_data SHALL be ignored outside IDLE; a requester holds req until its gnt.
REQ-022 A requester that keeps req high after its gnt SHALL be re-arbitrated as a new request.
REQ-023 Round-robin pointer: with all four requesting continuously, grants SHALL follow 0,1,2,3,0,...
REQ-024 A single active requester SHALL be granted back-to-back with no starvation penalty.
REQ-025 Minimum turnaround SHALL be one IDLE cycle between done and the next gnt.
REQ-026 gnt, done and err SHALL never be asserted simultaneously, and at most one bit of gnt or done SHALL be set.

Reset
REQ-027 On reset the FSM SHALL enter IDLE; gnt, done, err, Tx_WR and Tx_EN SHALL be 0; Tx_DATA SHALL be 8'h00; last SHALL be 3 (requester 0 first).
REQ-028 Reset during LOAD, WAIT_BUSY or WAIT_DONE SHALL abort the transfer without any done or err pulse.
REQ-029 The timeout counter SHALL clear to 0 on reset.

Configuration
REQ-030 With UART_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT_BUSY and in WAIT_DONE, clearing on every state entry.
REQ-031 With UART_ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES-1, err SHALL pulse, no done SHALL pulse, last SHALL be set to owner and the FSM SHALL return to IDLE.
REQ-032 Without UART_ARB_TIMEOUT_EN: there SHALL be no counter, err SHALL be tied to 0 and the FSM SHALL wait indefinitely for Tx_BUSY.

Verification
REQ-033 Reset, then req=4'b0100 with byte2=8'hA5 -> gnt=4'b0100 one cycle; next cycle Tx_WR=1 with Tx_DATA=8'hA5; after Tx_BUSY 1->0, done=4'b0100.
REQ-034 req=4'b1111 held for four frames -> gnt order 0001,0010,0100,1000.
REQ-035 req=4'b1001 after a grant to requester 0 -> next grant is 4'b1000; the grant after that is 4'b0001.
REQ-036 Assert reset in WAIT_DONE -> all outputs 0 next edge, no done; after release, req=4'b0011 -> gnt=4'b0001.
REQ-037 UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, Tx_BUSY held 0 after Tx_WR -> err pulses exactly 16 cycles after WAIT_BUSY entry, no done, FSM returns to IDLE.
REQ-038 Macro undefined, Tx_BUSY held 0 for 5000 cycles -> FSM stays in WAIT_BUSY, err=0 throughout, no gnt issued.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one uart_transmitter.
// Optional busy-wait timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        err,
    output logic [7:0]  Tx_DATA,
    output logic        Tx_WR,
    output logic        Tx_EN,
    input  logic        Tx_BUSY
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  last, last_nxt;
    logic [1:0]  owner, owner_nxt;
    logic [7:0]  data, data_nxt;
    logic [1:0]  winner;
    logic        timeout;

    logic [3:0]  gnt_nxt, done_nxt;
    logic        err_nxt, wr_nxt, en_nxt;
    logic [7:0]  tx_data_nxt;

    // Search order starts just after the last owner, so every requester waits at most three frames.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = last;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Restarts on every state entry, so WAIT_BUSY and WAIT_DONE each get a full budget.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            cnt <= '0;
        end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end
`else
    assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        owner_nxt = owner;
        data_nxt  = data;
        gnt_nxt   = 4'b0000;
        done_nxt  = 4'b0000;
        err_nxt   = 1'b0;
        wr_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt = winner;
                    data_nxt  = req_data[{winner, 3'b000} +: 8];
                    gnt_nxt   = 4'b0001 << winner;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                wr_nxt    = 1'b1;
                state_nxt = WAIT_BUSY;
            end
            // A real response from the transmitter wins over a timeout landing on the same cycle.
            WAIT_BUSY: begin
                if (Tx_BUSY) begin
                    state_nxt = WAIT_DONE;
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!Tx_BUSY) begin
                    done_nxt  = 4'b0001 << owner;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    err_nxt   = 1'b1;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        en_nxt      = (state_nxt != IDLE);
        tx_data_nxt = en_nxt ? data_nxt : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 2'd3;
            owner   <= 2'd0;
            data    <= 8'h00;
            gnt     <= 4'b0000;
            done    <= 4'b0000;
            err     <= 1'b0;
            Tx_WR   <= 1'b0;
            Tx_EN   <= 1'b0;
            Tx_DATA <= 8'h00;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            owner   <= owner_nxt;
            data    <= data_nxt;
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            Tx_WR   <= wr_nxt;
            Tx_EN   <= en_nxt;
            Tx_DATA <= tx_data_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized frames for uart_tx_arbiter against a round-robin reference model.
// Compile with UART_ARB_TIMEOUT_EN defined to exercise the timeout build.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_en;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;
    int last_m = 3;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .Tx_DATA  (tx_data),
        .Tx_WR    (tx_wr),
        .Tx_EN    (tx_en),
        .Tx_BUSY  (tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rule: first requester found scanning upward from the one after the last owner.
    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic exclusive_ok(input logic [3:0] g, input logic [3:0] d, input logic e);
        int active;
        active = (g != 0 ? 1 : 0) + (d != 0 ? 1 : 0) + (e ? 1 : 0);
        return $onehot0(g) && $onehot0(d) && (active <= 1);
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0) check("exclusive", {31'd0, exclusive_ok(gnt, done, err)}, 32'd1);
    end

    task automatic wait_gnt(output int cycles);
        cycles = 0;
        while (gnt == 4'b0000 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // One complete frame; every expectation comes from the model and the driven stimulus.
    task automatic frame(input logic [3:0] r, input logic [31:0] d, input int busy_dly,
                         input int busy_len, input logic [3:0] r_after);
        int w, cyc;
        logic [7:0] b;
        w = rr_pick(last_m, r);
        b = d[8*w +: 8];
        req = r;
        req_data = d;
        wait_gnt(cyc);
        check("gnt_latency", cyc, 1);
        check("gnt", {28'd0, gnt}, 32'(4'b0001 << w));
        req = r_after;
        req_data = $urandom();
        @(negedge clk);
        check("tx_wr", {31'd0, tx_wr}, 32'd1);
        check("tx_data", {24'd0, tx_data}, {24'd0, b});
        check("tx_en", {31'd0, tx_en}, 32'd1);
        check("gnt_pulse", {28'd0, gnt}, 32'd0);
        repeat (busy_dly) begin
            @(negedge clk);
            check("wr_pulse", {31'd0, tx_wr}, 32'd0);
            check("data_hold_b", {24'd0, tx_data}, {24'd0, b});
        end
        tx_busy = 1'b1;
        repeat (busy_len) begin
            @(negedge clk);
            check("early_done", {28'd0, done}, 32'd0);
            check("data_hold_d", {24'd0, tx_data}, {24'd0, b});
        end
        tx_busy = 1'b0;
        cyc = 0;
        while (done == 4'b0000 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("done_latency", cyc, 1);
        check("done", {28'd0, done}, 32'(4'b0001 << w));
        last_m = w;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cyc;
        logic [3:0] pending, seen_done;
        logic [3:0] exp_order [4];

        reset = 1'b1;
        req = 4'b0000;
        req_data = 32'd0;
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {gnt, done, err, tx_wr, tx_en, tx_data}, 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_low", {gnt, done, err, tx_wr, tx_en, tx_data}, 32'd0);
        end

        // Single request from requester 2 with byte A5.
        frame(4'b0100, 32'h00A5_0000, 2, 3, 4'b0000);
        check("first_owner", last_m, 2);

        // Park the pointer on 3, then all four requesting continuously.
        frame(4'b1000, 32'h5A00_0000, 0, 1, 4'b0000);
        exp_order = '{0, 1, 2, 3};
        for (int i = 0; i < 4; i++) begin
            frame(4'b1111, $urandom(), i, 2, 4'b1111);
            check("rr_order", last_m, exp_order[i]);
        end

        // Grant to 0, then 1001 must go to 3 before returning to 0.
        frame(4'b0001, $urandom(), 1, 1, 4'b0000);
        frame(4'b1001, $urandom(), 1, 2, 4'b1001);
        check("skip_to_3", last_m, 3);
        frame(4'b1001, $urandom(), 0, 1, 4'b0000);
        check("wrap_to_0", last_m, 0);

        // One requester held high is served back to back.
        for (int i = 0; i < 3; i++) frame(4'b0010, $urandom(), 0, 1, 4'b0010);
        req = 4'b0000;

        // Random arrivals; each requester holds req until its own grant.
        pending = 4'b0000;
        for (int i = 0; i < 24; i++) begin
            pending = pending | 4'($urandom_range(0, 15));
            if (pending == 4'b0000) pending = 4'b0001 << $urandom_range(0, 3);
            w = rr_pick(last_m, pending);
            frame(pending, $urandom(), $urandom_range(0, 4), $urandom_range(1, 6),
                  pending & ~(4'b0001 << w));
            pending = pending & ~(4'b0001 << w);
        end
        req = 4'b0000;
        @(negedge clk);

        // Reset while waiting for the transmitter to finish.
        req = 4'b0010;
        wait_gnt(cyc);
        check("pre_reset_gnt", {28'd0, gnt}, 32'(4'b0001 << rr_pick(last_m, 4'b0010)));
        req = 4'b0000;
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        check("in_wait_done", {31'd0, tx_en}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset", {gnt, done, err, tx_wr, tx_en, tx_data}, 32'd0);
        tx_busy = 1'b0;
        @(negedge clk);
        check("no_done_on_reset", {gnt, done, err, tx_wr, tx_en, tx_data}, 32'd0);
        reset = 1'b0;
        last_m = 3;
        @(negedge clk);
        check("post_reset_idle", {gnt, done, err, tx_wr, tx_en, tx_data}, 32'd0);
        frame(4'b0011, $urandom(), 1, 1, 4'b0000);
        check("post_reset_owner", last_m, 0);

        // Transmitter never raises busy.
        req = 4'b0100;
        w = rr_pick(last_m, 4'b0100);
        wait_gnt(cyc);
        check("stall_gnt", {28'd0, gnt}, 32'(4'b0001 << w));
        req = 4'b1011;
        @(negedge clk);
        check("stall_wr", {31'd0, tx_wr}, 32'd1);
`ifdef UART_ARB_TIMEOUT_EN
        cyc = 0;
        seen_done = 4'b0000;
        while (err !== 1'b1 && cyc < TO + 10) begin
            @(negedge clk);
            cyc++;
            seen_done = seen_done | done;
        end
        check("timeout_cycles", cyc, TO);
        check("timeout_no_done", {28'd0, seen_done}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        check("timeout_idle", {err, tx_en, tx_data}, 32'd0);
        last_m = w;
`else
        seen_done = 4'b0000;
        repeat (5000) begin
            @(negedge clk);
            check("stuck_wait", {22'd0, err, gnt, done, tx_en}, {22'd0, 1'b0, 4'b0000, 4'b0000, 1'b1});
        end
        tx_busy = 1'b1;
        @(negedge clk);
        tx_busy = 1'b0;
        cyc = 0;
        while (done == 4'b0000 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("late_done", {28'd0, done}, 32'(4'b0001 << w));
        last_m = w;
        req = 4'b0000;
`endif
        frame(4'b1011, $urandom(), 2, 2, 4'b0000);
        check("after_stall_owner", last_m, rr_pick(w, 4'b1011));

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
